// File: rtl/bus_arbiter.sv
// Two-master, one-slave round-robin arbiter for a valid/ready native memory bus.
// Forwards one transaction at a time and force-completes hung transactions after a timeout.
module bus_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter logic [31:0] TIMEOUT_RDATA  = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        m0_valid,
    output logic        m0_ready,
    input  logic        m0_instr,
    input  logic [31:0] m0_addr,
    input  logic [3:0]  m0_wstrb,
    input  logic [31:0] m0_wdata,
    output logic [31:0] m0_rdata,

    input  logic        m1_valid,
    output logic        m1_ready,
    input  logic        m1_instr,
    input  logic [31:0] m1_addr,
    input  logic [3:0]  m1_wstrb,
    input  logic [31:0] m1_wdata,
    output logic [31:0] m1_rdata,

    output logic        s_valid,
    input  logic        s_ready,
    output logic        s_instr,
    output logic [31:0] s_addr,
    output logic [3:0]  s_wstrb,
    output logic [31:0] s_wdata,
    input  logic [31:0] s_rdata,

    output logic [1:0]  grant,
    output logic        timeout,
    output logic        timeout_sticky
);

    localparam int unsigned CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES) + 1 : 1;
    localparam logic [CW-1:0] LIMIT = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t        state_q, state_nxt;
    logic [1:0]    grant_q, grant_nxt;
    logic          last_q, last_nxt;      // index of the master granted at the last contention
    logic [CW-1:0] cnt_q, cnt_nxt;
    logic          sticky_q, sticky_nxt;

    logic          sel;                   // 1 selects master 1
    logic          req_valid;
    logic          slave_done;
    logic          timeout_hit;
    logic          done;

    assign sel       = grant_q[1];
    assign req_valid = sel ? m1_valid : m0_valid;

    // NOTE: every variable assigned in this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt   = state_q;
        grant_nxt   = grant_q;
        last_nxt    = last_q;
        cnt_nxt     = cnt_q;
        sticky_nxt  = sticky_q;
        slave_done  = 1'b0;
        timeout_hit = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_nxt = '0;
                if (m0_valid && m1_valid) begin
                    grant_nxt = last_q ? 2'b01 : 2'b10;
                    last_nxt  = ~last_q;
                    state_nxt = BUSY;
                end else if (m0_valid) begin
                    grant_nxt = 2'b01;
                    state_nxt = BUSY;
                end else if (m1_valid) begin
                    grant_nxt = 2'b10;
                    state_nxt = BUSY;
                end
            end

            BUSY: begin
                // The slave wins a tie with the timeout so real data is never discarded.
                if (s_ready) begin
                    slave_done = 1'b1;
                end else if (TIMEOUT_EN && (cnt_q == LIMIT)) begin
                    timeout_hit = 1'b1;
                end

                if (slave_done || timeout_hit) begin
                    state_nxt  = IDLE;
                    grant_nxt  = 2'b00;
                    cnt_nxt    = '0;
                    sticky_nxt = sticky_q | timeout_hit;
                end else if (!req_valid) begin
                    state_nxt = IDLE;
                    grant_nxt = 2'b00;
                    cnt_nxt   = '0;
                end else if (cnt_q != {CW{1'b1}}) begin
                    cnt_nxt = cnt_q + 1'b1;
                end
            end

            default: begin
                state_nxt = IDLE;
                grant_nxt = 2'b00;
            end
        endcase
    end

    assign done = slave_done | timeout_hit;

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= IDLE;
            grant_q  <= 2'b00;
            last_q   <= 1'b1;
            cnt_q    <= '0;
            sticky_q <= 1'b0;
        end else begin
            state_q  <= state_nxt;
            grant_q  <= grant_nxt;
            last_q   <= last_nxt;
            cnt_q    <= cnt_nxt;
            sticky_q <= sticky_nxt;
        end
    end

    // Outputs are gated by resetn so nothing escapes while reset is held.
    logic        busy;
    logic [31:0] rdata_mux;

    assign busy      = (state_q == BUSY) && resetn;
    assign rdata_mux = timeout_hit ? TIMEOUT_RDATA : s_rdata;

    always_comb begin
        s_valid = busy;
        s_instr = 1'b0;
        s_addr  = '0;
        s_wstrb = '0;
        s_wdata = '0;
        if (busy) begin
            s_instr = sel ? m1_instr : m0_instr;
            s_addr  = sel ? m1_addr  : m0_addr;
            s_wstrb = sel ? m1_wstrb : m0_wstrb;
            s_wdata = sel ? m1_wdata : m0_wdata;
        end
    end

    assign m0_ready       = busy && grant_q[0] && done;
    assign m1_ready       = busy && grant_q[1] && done;
    assign m0_rdata       = (busy && grant_q[0]) ? rdata_mux : 32'h0;
    assign m1_rdata       = (busy && grant_q[1]) ? rdata_mux : 32'h0;
    assign grant          = resetn ? grant_q : 2'b00;
    assign timeout        = busy && timeout_hit;
    assign timeout_sticky = resetn && sticky_q;

endmodule
